psram_opi_responder: RTL and testbench

// - Device-side responder for the octal DDR PSRAM bus: the other end of the PSRAM controller pins (sck/ce/io/dqs).
// - Decodes cmd/addr/latency, serves linear-burst reads from an internal byte array and absorbs burst writes.
// - Synthesizable SoC-level bench partner and FPGA stand-in for the external PSRAM device.
// - Oversamples the bus with clk_i, which must be >= 8x the SCK frequency.

---
 rtl/psram_opi_responder.sv | 201 ++++++++++++++++++++
 tb/tb_psram_opi_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_opi_responder.sv
// Device-side octal DDR PSRAM responder: decodes cmd/addr/latency, serves linear burst reads and
// absorbs burst writes into an internal byte array. Define PSRAM_RESP_DM_EN to honour the dqs mask.
module psram_opi_responder #(
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned RD_LAT = 5,
  parameter int unsigned WR_LAT = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_en_i,
  input  logic [7:0] psram_io_out_i,
  input  logic       psram_dqs_en_i,
  input  logic       psram_dqs_out_i,
  output logic [7:0] psram_io_in_o,
  output logic       psram_dqs_in_o,
  output logic       busy_o,
  output logic       cmd_err_o
);

  localparam int unsigned MaxLat = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CntW   = $clog2(2 * MaxLat) + 2;

  localparam logic [7:0] CmdRead  = 8'h20;
  localparam logic [7:0] CmdWrite = 8'hA0;

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StWait, StRData, StWData, StIgnore
  } state_e;

  // Bus synchronizers; sck gets a third stage for edge detection.
  logic       sck_s1, sck_s2, sck_s3;
  logic       ce_s1, ce_s2;
  logic [7:0] io_s1, io_s2;
  logic [7:0] io_en_s1, io_en_s2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_s3   <= 1'b0;
      ce_s1    <= 1'b1;
      ce_s2    <= 1'b1;
      io_s1    <= '0;
      io_s2    <= '0;
      io_en_s1 <= '0;
      io_en_s2 <= '0;
    end else begin
      sck_s1   <= psram_sck_i;
      sck_s2   <= sck_s1;
      sck_s3   <= sck_s2;
      ce_s1    <= psram_ce_i;
      ce_s2    <= ce_s1;
      io_s1    <= psram_io_out_i;
      io_s2    <= io_s1;
      io_en_s1 <= psram_io_en_i;
      io_en_s2 <= io_en_s1;
    end
  end

  logic dm_mask;

`ifdef PSRAM_RESP_DM_EN
  logic dqs_out_s1, dqs_out_s2;
  logic dqs_en_s1, dqs_en_s2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dqs_out_s1 <= 1'b0;
      dqs_out_s2 <= 1'b0;
      dqs_en_s1  <= 1'b0;
      dqs_en_s2  <= 1'b0;
    end else begin
      dqs_out_s1 <= psram_dqs_out_i;
      dqs_out_s2 <= dqs_out_s1;
      dqs_en_s1  <= psram_dqs_en_i;
      dqs_en_s2  <= dqs_en_s1;
    end
  end

  assign dm_mask = dqs_en_s2 & dqs_out_s2;
`else
  logic unused_dqs;
  assign unused_dqs = psram_dqs_en_i ^ psram_dqs_out_i;
  assign dm_mask    = 1'b0;
`endif

  // A deasserted ce in the same sample masks any sck change, so ce always wins.
  logic edge_det;
  assign edge_det = ~ce_s2 & (sck_s2 ^ sck_s3);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [MEM_AW-1:0] ptr_q;
  logic [23:0]       addr_q;
  logic              is_rd_q;
  logic [7:0]        mem [2**MEM_AW];

  logic [31:0]     addr_full;
  logic [CntW-1:0] lat_last;
  logic            unused_addr;

  assign addr_full   = {addr_q, io_s2};
  assign lat_last    = is_rd_q ? CntW'(2 * RD_LAT - 1) : CntW'(2 * WR_LAT - 1);
  assign unused_addr = ^{addr_full[31:MEM_AW], addr_full[0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      ptr_q          <= '0;
      addr_q         <= '0;
      is_rd_q        <= 1'b0;
      psram_io_in_o  <= '0;
      psram_dqs_in_o <= 1'b0;
      cmd_err_o      <= 1'b0;
    end else begin
      cmd_err_o <= 1'b0;
      if (ce_s2) begin
        state_q        <= StIdle;
        cnt_q          <= '0;
        psram_io_in_o  <= '0;
        psram_dqs_in_o <= 1'b0;
      end else begin
        case (state_q)
          StIdle: state_q <= StCmd;
          StCmd: begin
            if (edge_det) begin
              cnt_q <= '0;
              if (io_s2 == CmdRead) begin
                is_rd_q <= 1'b1;
                state_q <= StAddr;
              end else if (io_s2 == CmdWrite) begin
                is_rd_q <= 1'b0;
                state_q <= StAddr;
              end else begin
                cmd_err_o <= 1'b1;
                state_q   <= StIgnore;
              end
            end
          end
          StAddr: begin
            if (edge_det) begin
              addr_q <= addr_full[23:0];
              if (cnt_q == CntW'(3)) begin
                ptr_q   <= {addr_full[MEM_AW-1:1], 1'b0};
                cnt_q   <= '0;
                state_q <= StWait;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StWait: begin
            if (edge_det) begin
              if (cnt_q == lat_last) begin
                cnt_q <= '0;
                if (is_rd_q) begin
                  // First read byte goes out on the last latency edge.
                  state_q        <= StRData;
                  psram_io_in_o  <= mem[ptr_q];
                  psram_dqs_in_o <= ~psram_dqs_in_o;
                  ptr_q          <= ptr_q + 1'b1;
                end else begin
                  state_q <= StWData;
                end
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StRData: begin
            if (edge_det) begin
              psram_io_in_o  <= mem[ptr_q];
              psram_dqs_in_o <= ~psram_dqs_in_o;
              ptr_q          <= ptr_q + 1'b1;
            end
          end
          StWData: begin
            if (edge_det) begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
          StIgnore: state_q <= StIgnore;
          default:  state_q <= StIdle;
        endcase
      end
    end
  end

  // Array is deliberately left out of reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == StWData && edge_det && io_en_s2 == 8'hFF && !dm_mask) begin
      mem[ptr_q] <= io_s2;
    end
  end

  assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_psram_opi_responder.sv
// Directed bench for psram_opi_responder: write/read bursts, wrap, odd start, bad command,
// aborted read and byte masking.
module tb_psram_opi_responder;

  localparam int unsigned RdLat = 5;
  localparam int unsigned WrLat = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       ce;
  logic [7:0] io_en;
  logic [7:0] io_out;
  logic       dqs_en;
  logic       dqs_out;
  logic [7:0] io_in;
  logic       dqs_in;
  logic       busy;
  logic       cmd_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] wr_data [8];
  logic [7:0] wr_en [8];
  logic       wr_dm [8];
  logic [7:0] rd_data [8];
  logic       rd_dqs [8];

  psram_opi_responder #(
    .MEM_AW(10),
    .RD_LAT(RdLat),
    .WR_LAT(WrLat)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .psram_sck_i    (sck),
    .psram_ce_i     (ce),
    .psram_io_en_i  (io_en),
    .psram_io_out_i (io_out),
    .psram_dqs_en_i (dqs_en),
    .psram_dqs_out_i(dqs_out),
    .psram_io_in_o  (io_in),
    .psram_dqs_in_o (dqs_in),
    .busy_o         (busy),
    .cmd_err_o      (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_edge(input logic [7:0] d, input logic [7:0] en, input logic dm);
    io_out  = d;
    io_en   = en;
    dqs_out = dm;
    sck     = ~sck;
    wait_clks(4);
  endtask

  task automatic ce_high();
    ce     = 1'b1;
    io_en  = 8'h00;
    dqs_en = 1'b0;
    wait_clks(4);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr);
    ce = 1'b0;
    wait_clks(4);
    bus_edge(cmd, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) bus_edge(addr[31-8*i -: 8], 8'hFF, 1'b0);
  endtask

  task automatic latency(input int n);
    for (int i = 0; i < n; i++) bus_edge(8'h00, 8'h00, 1'b0);
  endtask

  task automatic write_burst(input logic [31:0] addr, input int n);
    send_hdr(8'hA0, addr);
    latency(2 * WrLat);
    dqs_en = 1'b1;
    for (int k = 0; k < n; k++) bus_edge(wr_data[k], wr_en[k], wr_dm[k]);
    ce_high();
  endtask

  task automatic read_burst(input logic [31:0] addr, input int n);
    send_hdr(8'h20, addr);
    latency(2 * RdLat);
    rd_data[0] = io_in;
    rd_dqs[0]  = dqs_in;
    for (int k = 1; k < n; k++) begin
      bus_edge(8'h00, 8'h00, 1'b0);
      rd_data[k] = io_in;
      rd_dqs[k]  = dqs_in;
    end
    ce_high();
  endtask

  task automatic set_plain_write(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3);
    wr_data[0] = b0; wr_data[1] = b1; wr_data[2] = b2; wr_data[3] = b3;
    for (int i = 0; i < 8; i++) begin
      wr_en[i] = 8'hFF;
      wr_dm[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(3);
    checks++; if (io_in !== 8'h00) begin failures++; $display("FAIL reset_io got=%0h exp=0", io_in); end
    checks++; if (dqs_in !== 1'b0) begin failures++; $display("FAIL reset_dqs got=%0b exp=0", dqs_in); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", cmd_err); end
    rst = 1'b0;
    wait_clks(2);
  endtask

  task automatic test_write_read();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    set_plain_write(8'h11, 8'h22, 8'h33, 8'h44);
    write_burst(32'h0000_0010, 4);
    read_burst(32'h0000_0010, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_data[k] !== exp_b[k]) begin
        failures++; $display("FAIL wr_rd_data[%0d] got=%0h exp=%0h", k, rd_data[k], exp_b[k]);
      end
      checks++;
      if (rd_dqs[k] !== ((k % 2) == 0)) begin
        failures++; $display("FAIL wr_rd_dqs[%0d] got=%0b exp=%0b", k, rd_dqs[k], (k % 2) == 0);
      end
    end
    checks++; if (io_in !== 8'h00) begin failures++; $display("FAIL post_io got=%0h exp=0", io_in); end
    checks++; if (dqs_in !== 1'b0) begin failures++; $display("FAIL post_dqs got=%0b exp=0", dqs_in); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hC1; exp_b[1] = 8'hC2; exp_b[2] = 8'hC3; exp_b[3] = 8'hC4;
    set_plain_write(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    write_burst(32'h0000_03FE, 4);
    // Upper address bits must be ignored.
    read_burst(32'h1234_03FE, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_data[k] !== exp_b[k]) begin
        failures++; $display("FAIL wrap_data[%0d] got=%0h exp=%0h", k, rd_data[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_odd_start();
    set_plain_write(8'hAA, 8'hBB, 8'h00, 8'h00);
    write_burst(32'h0000_0021, 2);
    read_burst(32'h0000_0020, 2);
    checks++; if (rd_data[0] !== 8'hAA) begin failures++; $display("FAIL odd_b0 got=%0h exp=aa", rd_data[0]); end
    checks++; if (rd_data[1] !== 8'hBB) begin failures++; $display("FAIL odd_b1 got=%0h exp=bb", rd_data[1]); end
  endtask

  task automatic test_bad_cmd();
    int pulses;
    int first_at;
    pulses   = 0;
    first_at = -1;
    ce = 1'b0;
    wait_clks(4);
    io_out = 8'h55;
    io_en  = 8'hFF;
    sck    = ~sck;
    for (int i = 1; i <= 8; i++) begin
      wait_clks(1);
      if (cmd_err === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL err_pulses got=%0d exp=1", pulses); end
    checks++; if (first_at != 3) begin failures++; $display("FAIL err_timing got=%0d exp=3", first_at); end
    for (int i = 0; i < 2; i++) begin
      bus_edge(8'h5A, 8'hFF, 1'b0);
      checks++; if (io_in !== 8'h00) begin failures++; $display("FAIL ign_io got=%0h exp=0", io_in); end
      checks++; if (dqs_in !== 1'b0) begin failures++; $display("FAIL ign_dqs got=%0b exp=0", dqs_in); end
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%0b exp=1", busy); end
    ce = 1'b1;
    wait_clks(2);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_hold got=%0b exp=1", busy); end
    wait_clks(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_drop got=%0b exp=0", busy); end
    io_en = 8'h00;
    wait_clks(2);
  endtask

  task automatic test_abort();
    send_hdr(8'h20, 32'h0000_0010);
    latency(4);
    ce_high();
    checks++; if (io_in !== 8'h00) begin failures++; $display("FAIL abort_io got=%0h exp=0", io_in); end
    checks++; if (dqs_in !== 1'b0) begin failures++; $display("FAIL abort_dqs got=%0b exp=0", dqs_in); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    read_burst(32'h0000_0010, 2);
    checks++; if (rd_data[0] !== 8'h11) begin failures++; $display("FAIL reread_b0 got=%0h exp=11", rd_data[0]); end
    checks++; if (rd_dqs[0] !== 1'b1) begin failures++; $display("FAIL reread_dqs0 got=%0b exp=1", rd_dqs[0]); end
    checks++; if (rd_data[1] !== 8'h22) begin failures++; $display("FAIL reread_b1 got=%0h exp=22", rd_data[1]); end
    checks++; if (rd_dqs[1] !== 1'b0) begin failures++; $display("FAIL reread_dqs1 got=%0b exp=0", rd_dqs[1]); end
  endtask

  task automatic test_mask();
    logic [7:0] exp_b [4];
    set_plain_write(8'h01, 8'h02, 8'h03, 8'h04);
    write_burst(32'h0000_0040, 4);
    set_plain_write(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    wr_dm[1] = 1'b1;
    wr_en[2] = 8'h0F;
    write_burst(32'h0000_0040, 4);
    exp_b[0] = 8'hA1;
`ifdef PSRAM_RESP_DM_EN
    exp_b[1] = 8'h02;
`else
    exp_b[1] = 8'hA2;
`endif
    exp_b[2] = 8'h03;
    exp_b[3] = 8'hA4;
    read_burst(32'h0000_0040, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_data[k] !== exp_b[k]) begin
        failures++; $display("FAIL mask_data[%0d] got=%0h exp=%0h", k, rd_data[k], exp_b[k]);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    sck     = 1'b0;
    ce      = 1'b1;
    io_en   = 8'h00;
    io_out  = 8'h00;
    dqs_en  = 1'b0;
    dqs_out = 1'b0;
    test_reset();
    test_write_read();
    test_wrap();
    test_odd_start();
    test_bad_cmd();
    test_abort();
    test_mask();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
